// File: rtl/pipe_tx_fifo_arbiter_if.sv
// Write-port bundle shared by the TLP/DLLP sources, the TX FIFO and the arbiter.
// The master side drives requests, beats and FIFO status; the slave side is the arbiter.
interface pipe_tx_fifo_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             tlp_req;
    logic [511:0]     tlp_data;
    logic [63:0]      tlp_valid;
    logic [63:0]      tlp_stp;
    logic [63:0]      tlp_end;
    logic             tlp_gnt;
    logic             dllp_req;
    logic [511:0]     dllp_data;
    logic [63:0]      dllp_valid;
    logic [63:0]      dllp_sdp;
    logic [63:0]      dllp_end;
    logic             dllp_gnt;
    logic             fifo_full;
    logic             fifo_wr;
    logic [511:0]     fifo_data_in;
    logic [63:0]      fifo_wr_valid;
    logic [63:0]      fifo_stp;
    logic [63:0]      fifo_sdp;
    logic [63:0]      fifo_end;
    logic             busy;
    logic             protocol_err;
    logic [CNT_W-1:0] tlp_pkt_cnt;
    logic [CNT_W-1:0] dllp_pkt_cnt;

    modport master (
        output tlp_req, tlp_data, tlp_valid, tlp_stp, tlp_end,
        output dllp_req, dllp_data, dllp_valid, dllp_sdp, dllp_end,
        output fifo_full,
        input  tlp_gnt, dllp_gnt, fifo_wr, fifo_data_in, fifo_wr_valid,
        input  fifo_stp, fifo_sdp, fifo_end, busy, protocol_err,
        input  tlp_pkt_cnt, dllp_pkt_cnt
    );

    modport slave (
        input  tlp_req, tlp_data, tlp_valid, tlp_stp, tlp_end,
        input  dllp_req, dllp_data, dllp_valid, dllp_sdp, dllp_end,
        input  fifo_full,
        output tlp_gnt, dllp_gnt, fifo_wr, fifo_data_in, fifo_wr_valid,
        output fifo_stp, fifo_sdp, fifo_end, busy, protocol_err,
        output tlp_pkt_cnt, dllp_pkt_cnt
    );
endinterface

// File: rtl/pipe_tx_fifo_arbiter.sv
// Packet-granular scheduler for the PIPE TX FIFO write port: DLLPs win arbitration,
// a burst limit guarantees TLP progress, and framing errors raise a sticky flag.
module pipe_tx_fifo_arbiter #(
    parameter int MAX_DLLP_BURST = 4,
    parameter int CNT_W          = 16
) (
    input  logic                  pclk,
    input  logic                  reset_n,
    pipe_tx_fifo_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TLP  = 2'd1,
        ST_DLLP = 2'd2
    } state_t;

    localparam logic [3:0]       L_MAX_BURST = 4'(MAX_DLLP_BURST);
    localparam logic [CNT_W-1:0] L_CNT_MAX   = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_tlp_gnt;
    logic             r_dllp_gnt;
    logic             r_busy;
    logic             r_first;
    logic             r_err;
    logic [3:0]       r_burst;
    logic [CNT_W-1:0] r_tlp_cnt;
    logic [CNT_W-1:0] r_dllp_cnt;

    logic             w_tlp_acc;
    logic             w_dllp_acc;
    logic             w_tlp_last;
    logic             w_dllp_last;
    logic             w_arb;
    logic             w_err_set;
    logic [3:0]       w_burst_nxt;
    state_t           w_state_nxt;
    logic [511:0]     w_data;
    logic [63:0]      w_valid;
    logic [63:0]      w_stp;
    logic [63:0]      w_sdp;
    logic [63:0]      w_end;

    assign w_tlp_acc   = r_tlp_gnt & bus.tlp_req & ~bus.fifo_full;
    assign w_dllp_acc  = r_dllp_gnt & bus.dllp_req & ~bus.fifo_full;
    assign w_tlp_last  = w_tlp_acc & (|bus.tlp_end);
    assign w_dllp_last = w_dllp_acc & (|bus.dllp_end);
    assign w_arb       = (r_state == ST_IDLE) | w_tlp_last | w_dllp_last;

    // r_first marks that the next accepted beat opens a packet
    assign w_err_set = (w_tlp_acc & r_first & ~(|bus.tlp_stp))
                     | (w_dllp_acc & r_first & ~(|bus.dllp_sdp))
                     | (w_tlp_acc & ~r_first & (|bus.tlp_stp));

    // Burst count of DLLPs completed while a TLP waits; the updated value feeds arbitration
    always_comb begin
        w_burst_nxt = r_burst;
        if (w_tlp_last) begin
            w_burst_nxt = 4'd0;
        end else if (w_dllp_last) begin
            if (!bus.tlp_req) begin
                w_burst_nxt = 4'd0;
            end else if (r_burst >= L_MAX_BURST) begin
                w_burst_nxt = L_MAX_BURST;
            end else begin
                w_burst_nxt = r_burst + 4'd1;
            end
        end else begin
            w_burst_nxt = r_burst;
        end
    end

    // Next owner, decided only at packet boundaries
    always_comb begin
        w_state_nxt = r_state;
        if (w_arb) begin
            if (bus.dllp_req && !(bus.tlp_req && (w_burst_nxt == L_MAX_BURST))) begin
                w_state_nxt = ST_DLLP;
            end else if (bus.tlp_req) begin
                w_state_nxt = ST_TLP;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Zero-latency FIFO write mux; outputs are forced to zero whenever nothing is written
    always_comb begin
        w_data  = 512'd0;
        w_valid = 64'd0;
        w_stp   = 64'd0;
        w_sdp   = 64'd0;
        w_end   = 64'd0;
        if (w_tlp_acc) begin
            w_data  = bus.tlp_data;
            w_valid = bus.tlp_valid;
            w_stp   = bus.tlp_stp;
            w_end   = bus.tlp_end;
        end else if (w_dllp_acc) begin
            w_data  = bus.dllp_data;
            w_valid = bus.dllp_valid;
            w_sdp   = bus.dllp_sdp;
            w_end   = bus.dllp_end;
        end else begin
            w_data  = 512'd0;
            w_valid = 64'd0;
        end
    end

    // Owner state, registered grants, burst, framing and packet counters
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tlp_gnt  <= 1'b0;
            r_dllp_gnt <= 1'b0;
            r_busy     <= 1'b0;
            r_first    <= 1'b1;
            r_err      <= 1'b0;
            r_burst    <= 4'd0;
            r_tlp_cnt  <= {CNT_W{1'b0}};
            r_dllp_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_tlp_gnt  <= (w_state_nxt == ST_TLP);
            r_dllp_gnt <= (w_state_nxt == ST_DLLP);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_burst    <= w_burst_nxt;
            if (w_arb) begin
                r_first <= 1'b1;
            end else if (w_tlp_acc || w_dllp_acc) begin
                r_first <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_tlp_last && (r_tlp_cnt != L_CNT_MAX)) begin
                r_tlp_cnt <= r_tlp_cnt + CNT_W'(1);
            end
            if (w_dllp_last && (r_dllp_cnt != L_CNT_MAX)) begin
                r_dllp_cnt <= r_dllp_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.tlp_gnt       = r_tlp_gnt;
    assign bus.dllp_gnt      = r_dllp_gnt;
    assign bus.busy          = r_busy;
    assign bus.protocol_err  = r_err;
    assign bus.tlp_pkt_cnt   = r_tlp_cnt;
    assign bus.dllp_pkt_cnt  = r_dllp_cnt;
    assign bus.fifo_wr       = w_tlp_acc | w_dllp_acc;
    assign bus.fifo_data_in  = w_data;
    assign bus.fifo_wr_valid = w_valid;
    assign bus.fifo_stp      = w_stp;
    assign bus.fifo_sdp      = w_sdp;
    assign bus.fifo_end      = w_end;
endmodule

// File: tb/tb_pipe_tx_fifo_arbiter.sv
// Directed plus randomized bench for pipe_tx_fifo_arbiter with a packet-level reference
// model; a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_pipe_tx_fifo_arbiter;
    localparam int MAXB  = 4;
    localparam int CMAX  = 65535;
    localparam int CMAX2 = 3;

    logic pclk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    pipe_tx_fifo_arbiter_if #(.CNT_W(16)) bus ();
    pipe_tx_fifo_arbiter_if #(.CNT_W(2))  bus2 ();

    pipe_tx_fifo_arbiter #(.MAX_DLLP_BURST(MAXB), .CNT_W(16)) dut  (.pclk(pclk), .reset_n(reset_n), .bus(bus));
    pipe_tx_fifo_arbiter #(.MAX_DLLP_BURST(MAXB), .CNT_W(2))  dut2 (.pclk(pclk), .reset_n(reset_n), .bus(bus2));

    assign bus2.tlp_req    = bus.tlp_req;
    assign bus2.tlp_data   = bus.tlp_data;
    assign bus2.tlp_valid  = bus.tlp_valid;
    assign bus2.tlp_stp    = bus.tlp_stp;
    assign bus2.tlp_end    = bus.tlp_end;
    assign bus2.dllp_req   = bus.dllp_req;
    assign bus2.dllp_data  = bus.dllp_data;
    assign bus2.dllp_valid = bus.dllp_valid;
    assign bus2.dllp_sdp   = bus.dllp_sdp;
    assign bus2.dllp_end   = bus.dllp_end;
    assign bus2.fifo_full  = bus.fifo_full;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: owner 0=none 1=TLP 2=DLLP, DLLP run length while a TLP waits
    int m_own, m_run, m_tcnt, m_dcnt;
    bit m_first, m_err;
    bit acc_t, acc_d;
    logic obs_wr, obs_tgnt;
    int wr_seen;

    // Random source bookkeeping
    bit t_act, d_act;
    int t_len, t_idx, d_len, d_idx;
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_run = 0; m_tcnt = 0; m_dcnt = 0;
        m_first = 1'b1; m_err = 1'b0; acc_t = 1'b0; acc_d = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.tlp_req = 1'b0; bus.tlp_data = '0; bus.tlp_valid = '0; bus.tlp_stp = '0; bus.tlp_end = '0;
        bus.dllp_req = 1'b0; bus.dllp_data = '0; bus.dllp_valid = '0; bus.dllp_sdp = '0; bus.dllp_end = '0;
        bus.fifo_full = 1'b0;
    endtask

    task automatic set_tlp_beat(input bit first, input bit last);
        for (int i = 0; i < 16; i++) bus.tlp_data[i*32 +: 32] = $urandom;
        bus.tlp_valid = {$urandom, $urandom};
        bus.tlp_stp   = first ? (64'h1 << $urandom_range(63)) : 64'h0;
        bus.tlp_end   = last  ? (64'h1 << $urandom_range(63)) : 64'h0;
    endtask

    task automatic set_dllp_beat(input bit first, input bit last);
        for (int i = 0; i < 16; i++) bus.dllp_data[i*32 +: 32] = $urandom;
        bus.dllp_valid = {$urandom, $urandom};
        bus.dllp_sdp   = first ? (64'h1 << $urandom_range(63)) : 64'h0;
        bus.dllp_end   = last  ? (64'h1 << $urandom_range(63)) : 64'h0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge
    task automatic step(input string tag);
        logic at, ad, tr, dr, t_last, d_last, bad;
        logic [511:0] e_data;
        logic [63:0]  e_val, e_stp, e_sdp, e_end;
        #1;
        tr = bus.tlp_req;
        dr = bus.dllp_req;
        at = (m_own == 1) && tr && !bus.fifo_full;
        ad = (m_own == 2) && dr && !bus.fifo_full;
        e_data = '0; e_val = '0; e_stp = '0; e_sdp = '0; e_end = '0;
        if (at) begin
            e_data = bus.tlp_data; e_val = bus.tlp_valid; e_stp = bus.tlp_stp; e_end = bus.tlp_end;
        end else if (ad) begin
            e_data = bus.dllp_data; e_val = bus.dllp_valid; e_sdp = bus.dllp_sdp; e_end = bus.dllp_end;
        end
        obs_wr   = bus.fifo_wr;
        obs_tgnt = bus.tlp_gnt;
        if (bus.fifo_wr === 1'b1) wr_seen++;
        chk({tag, ".wr"},    bus.fifo_wr, at || ad);
        chk({tag, ".data"},  bus.fifo_data_in, e_data);
        chk({tag, ".valid"}, bus.fifo_wr_valid, e_val);
        chk({tag, ".stp"},   bus.fifo_stp, e_stp);
        chk({tag, ".sdp"},   bus.fifo_sdp, e_sdp);
        chk({tag, ".end"},   bus.fifo_end, e_end);
        chk({tag, ".tgnt"},  bus.tlp_gnt, m_own == 1);
        chk({tag, ".dgnt"},  bus.dllp_gnt, m_own == 2);
        chk({tag, ".busy"},  bus.busy, m_own != 0);
        chk({tag, ".err"},   bus.protocol_err, m_err);
        chk({tag, ".tcnt"},  bus.tlp_pkt_cnt, m_tcnt);
        chk({tag, ".dcnt"},  bus.dllp_pkt_cnt, m_dcnt);
        chk({tag, ".tcnt2"}, bus2.tlp_pkt_cnt, (m_tcnt > CMAX2) ? CMAX2 : m_tcnt);
        chk({tag, ".dcnt2"}, bus2.dllp_pkt_cnt, (m_dcnt > CMAX2) ? CMAX2 : m_dcnt);
        t_last = at && (bus.tlp_end != 64'h0);
        d_last = ad && (bus.dllp_end != 64'h0);
        bad = (at && m_first && bus.tlp_stp == 64'h0) || (ad && m_first && bus.dllp_sdp == 64'h0)
           || (at && !m_first && bus.tlp_stp != 64'h0);
        @(posedge pclk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (bad) m_err = 1'b1;
            if (t_last && m_tcnt < CMAX) m_tcnt++;
            if (d_last && m_dcnt < CMAX) m_dcnt++;
            if (t_last) m_run = 0;
            else if (d_last) m_run = tr ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 0;
            if (m_own == 0 || t_last || d_last) begin
                if (dr && !(tr && m_run == MAXB)) m_own = 2;
                else if (tr) m_own = 1;
                else m_own = 0;
                m_first = 1'b1;
            end else if (at || ad) begin
                m_first = 1'b0;
            end
            acc_t = at;
            acc_d = ad;
        end
        @(negedge pclk);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, ".tgnt"}, bus.tlp_gnt, 1'b0);
        chk({tag, ".dgnt"}, bus.dllp_gnt, 1'b0);
        chk({tag, ".busy"}, bus.busy, 1'b0);
        chk({tag, ".err"},  bus.protocol_err, 1'b0);
        chk({tag, ".wr"},   bus.fifo_wr, 1'b0);
        chk({tag, ".tcnt"}, bus.tlp_pkt_cnt, 16'd0);
        chk({tag, ".dcnt"}, bus.dllp_pkt_cnt, 16'd0);
        chk({tag, ".cnt2"}, bus2.tlp_pkt_cnt, 2'd0);
    endtask

    task automatic pulse_reset(input string tag);
        clear_inputs();
        reset_n = 1'b0;
        #1;
        reset_values(tag);
        model_reset();
        @(negedge pclk);
        reset_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset_n = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        reset_values("rst0");
        reset_n = 1'b1;

        // Single 3-beat TLP
        wr_seen = 0;
        bus.tlp_req = 1'b1; set_tlp_beat(1'b1, 1'b0); bus.tlp_stp = 64'h1;
        step("t1_idle");
        chk("t1_gnt", bus.tlp_gnt, 1'b1);
        step("t1_b0");
        set_tlp_beat(1'b0, 1'b0);
        step("t1_b1");
        set_tlp_beat(1'b0, 1'b0); bus.tlp_end = 64'h8000_0000_0000_0000;
        step("t1_b2");
        bus.tlp_req = 1'b0;
        chk("t1_writes", wr_seen, 3);
        chk("t1_cnt", bus.tlp_pkt_cnt, 16'd1);
        chk("t1_err", bus.protocol_err, 1'b0);

        // DLLP priority with burst limit, both sources streaming 1-beat packets
        bus.tlp_req = 1'b1; set_tlp_beat(1'b1, 1'b1);
        bus.dllp_req = 1'b1; set_dllp_beat(1'b1, 1'b1);
        for (int k = 0; k < 15; k++) begin
            step("t2");
            chk("t2_nobubble", obs_wr, 1'b1);
            chk("t2_order", obs_tgnt, (k % 5) == 0);
        end
        bus.tlp_req = 1'b0; bus.dllp_req = 1'b0;

        // FIFO full back-pressure in the middle of a TLP
        wr_seen = 0;
        bus.tlp_req = 1'b1; set_tlp_beat(1'b1, 1'b0);
        step("t3_b0");
        set_tlp_beat(1'b0, 1'b0);
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step("t3_full");
            chk("t3_full_wr", obs_wr, 1'b0);
            chk("t3_full_gnt", obs_tgnt, 1'b1);
        end
        bus.fifo_full = 1'b0;
        step("t3_b1");
        set_tlp_beat(1'b0, 1'b1);
        step("t3_b2");
        bus.tlp_req = 1'b0;
        chk("t3_writes", wr_seen, 3);

        // Randomized traffic with correct framing, random stalls and dropped requests
        t_act = 1'b0; d_act = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!t_act && $urandom_range(3) == 0) begin
                t_act = 1'b1; t_len = $urandom_range(1, 4); t_idx = 0;
                set_tlp_beat(1'b1, t_len == 1);
            end else if (!t_act) begin
                set_tlp_beat(1'b1, 1'b1); bus.tlp_stp = {$urandom, $urandom};
            end
            if (!d_act && $urandom_range(3) == 0) begin
                d_act = 1'b1; d_len = $urandom_range(1, 3); d_idx = 0;
                set_dllp_beat(1'b1, d_len == 1);
            end else if (!d_act) begin
                set_dllp_beat(1'b0, 1'b1); bus.dllp_sdp = {$urandom, $urandom};
            end
            bus.tlp_req   = t_act && ($urandom_range(7) != 0);
            bus.dllp_req  = d_act && ($urandom_range(7) != 0);
            bus.fifo_full = ($urandom_range(4) == 0);
            step("rnd");
            if (acc_t) begin
                t_idx++;
                if (t_idx == t_len) t_act = 1'b0;
                else set_tlp_beat(1'b0, t_idx == t_len - 1);
            end
            if (acc_d) begin
                d_idx++;
                if (d_idx == d_len) d_act = 1'b0;
                else set_dllp_beat(1'b0, d_idx == d_len - 1);
            end
        end

        // Framing error is sticky across good packets; the burst limit then hands over to a TLP
        pulse_reset("rst1");
        bus.tlp_req = 1'b1; set_tlp_beat(1'b1, 1'b0);
        bus.dllp_req = 1'b1; set_dllp_beat(1'b1, 1'b1); bus.dllp_sdp = 64'h0;
        step("f_idle");
        step("f_d0");
        chk("f_err_set", bus.protocol_err, 1'b1);
        set_dllp_beat(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step("f_d");
            chk("f_err_hold", bus.protocol_err, 1'b1);
        end
        chk("f_tlp_forced", bus.tlp_gnt, 1'b1);
        bus.dllp_req = 1'b0;
        step("f_t0");
        set_tlp_beat(1'b0, 1'b0);
        step("f_t1");

        // Asynchronous reset during beat 2 of the TLP
        set_tlp_beat(1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        reset_values("rst_mid");
        model_reset();
        @(negedge pclk);
        clear_inputs();
        reset_n = 1'b1;
        bus.dllp_req = 1'b1; set_dllp_beat(1'b1, 1'b1);
        step("r_idle");
        chk("r_dgnt", bus.dllp_gnt, 1'b1);
        step("r_d0");
        bus.dllp_req = 1'b0;
        chk("r_dcnt", bus.dllp_pkt_cnt, 16'd1);

        // Counter saturation on the 2-bit instance
        pulse_reset("rst2");
        bus.tlp_req = 1'b1; set_tlp_beat(1'b1, 1'b1);
        step("s_idle");
        for (int k = 0; k < 5; k++) begin
            step("s_pkt");
            chk("s_sat2", bus2.tlp_pkt_cnt, sat_exp[k]);
            chk("s_cnt16", bus.tlp_pkt_cnt, k + 1);
        end
        bus.tlp_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
